// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop synchronizer, counter debouncer, registered
// press/release pulses and optional auto-repeat of press pulses while a key is held.
module key_conditioner #(
  parameter int unsigned       N_KEYS          = 5,
  parameter int unsigned       DEBOUNCE_CYCLES = 500000,
  parameter int unsigned       REPEAT_DELAY    = 25000000,
  parameter int unsigned       REPEAT_PERIOD   = 5000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = 5'b00010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw_i,
  output logic [N_KEYS-1:0] key_level_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_release_o
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rpt_state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] stable_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;
  logic [DbW-1:0]    db_cnt_q [N_KEYS];
  logic [DbW-1:0]    db_cnt_d [N_KEYS];
  rpt_state_e        state_q  [N_KEYS];
  logic [RptW-1:0]   rpt_cnt_q [N_KEYS];

  logic [N_KEYS-1:0] differ;
  logic [N_KEYS-1:0] toggle;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] fall;

  // Any cycle of agreement clears the count, so only sustained disagreement toggles.
  always_comb begin
    differ = '0;
    toggle = '0;
    rise   = '0;
    fall   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      db_cnt_d[i] = '0;
      differ[i]   = sync2_q[i] ^ stable_q[i];
      toggle[i]   = differ[i] && (db_cnt_q[i] == DbLast);
      rise[i]     = toggle[i] & ~stable_q[i];
      fall[i]     = toggle[i] & stable_q[i];
      if (differ[i] && !toggle[i]) begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      release_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= key_raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_q ^ toggle;
      release_q <= fall;
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Repeat FSM; a debounced fall wins over a coincident repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i]   <= StIdle;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        press_q[i] <= rise[i];
        case (state_q[i])
          StIdle: begin
            rpt_cnt_q[i] <= '0;
            if (rise[i] && REPEAT_MASK[i]) begin
              state_q[i] <= StDelay;
            end
          end
          StDelay: begin
            if (fall[i]) begin
              state_q[i]   <= StIdle;
              rpt_cnt_q[i] <= '0;
            end else if (rpt_cnt_q[i] == DelayLast) begin
              press_q[i]   <= 1'b1;
              rpt_cnt_q[i] <= '0;
              state_q[i]   <= StRepeat;
            end else begin
              rpt_cnt_q[i] <= rpt_cnt_q[i] + RptW'(1);
            end
          end
          StRepeat: begin
            if (fall[i]) begin
              state_q[i]   <= StIdle;
              rpt_cnt_q[i] <= '0;
            end else if (rpt_cnt_q[i] == PeriodLast) begin
              press_q[i]   <= 1'b1;
              rpt_cnt_q[i] <= '0;
            end else begin
              rpt_cnt_q[i] <= rpt_cnt_q[i] + RptW'(1);
            end
          end
          default: begin
            state_q[i]   <= StIdle;
            rpt_cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  assign key_level_o   = stable_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: expected pulses are queued with their cycle number when
// stimulus is driven and matched against the DUT outputs on every falling edge.
module tb_key_conditioner;

  localparam int unsigned NK = 5;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  typedef struct {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  key_conditioner #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (5'b00010)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_raw_i    (key_raw),
    .key_level_o  (key_level),
    .key_press_o  (key_press),
    .key_release_o(key_release)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every sampled cycle either matches a queued pulse or shows no pulse at all.
  always @(negedge clk) begin
    checks++;
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      if (key_press !== e.press || key_release !== e.rel) begin
        errors++;
        $display("FAIL pulse cyc=%0d press=%b release=%b required press=%b release=%b",
                 cyc, key_press, key_release, e.press, e.rel);
      end
    end else if ((key_press | key_release) !== '0) begin
      errors++;
      $display("FAIL spurious_pulse cyc=%0d press=%b release=%b required none",
               cyc, key_press, key_release);
    end
  end

  function automatic exp_t mk(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r);
    exp_t x;
    x.cyc   = c;
    x.press = p;
    x.rel   = r;
    return x;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    key_raw = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (key_level !== '0 || key_press !== '0 || key_release !== '0) begin
      errors++;
      $display("FAIL reset_outputs level=%b press=%b release=%b required all 0",
               key_level, key_press, key_release);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (key_level !== '0) begin
      errors++;
      $display("FAIL idle_level got %b required 00000", key_level);
    end
  endtask

  task automatic test_clean_press();
    int c0;
    c0 = cyc;
    key_raw[0] = 1'b1;
    exp_q.push_back(mk(c0 + 6, 5'b00001, 5'b00000));
    exp_q.push_back(mk(c0 + 26, 5'b00000, 5'b00001));
    repeat (20) begin
      @(negedge clk);
      if (cyc == c0 + 5 || cyc == c0 + 6) begin
        checks++;
        if (key_level[0] !== (cyc == c0 + 6)) begin
          errors++;
          $display("FAIL clean_level cyc=%0d got %b required %b", cyc - c0, key_level[0],
                   cyc == c0 + 6);
        end
      end
    end
    key_raw[0] = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || key_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL clean_done pending=%0d level=%b required 0 and 0", exp_q.size(),
               key_level[0]);
    end
  endtask

  task automatic test_bounce();
    int cl;
    for (int s = 0; s < 6; s++) begin
      key_raw[0] = (s % 2 == 0);
      repeat (2) @(negedge clk);
    end
    checks++;
    if (key_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level got %b required 0", key_level[0]);
    end
    key_raw[0] = 1'b1;
    cl = cyc;
    exp_q.push_back(mk(cl + 6, 5'b00001, 5'b00000));
    repeat (10) @(negedge clk);
    checks++;
    if (key_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_settled got %b required 1", key_level[0]);
    end
    key_raw[0] = 1'b0;
    exp_q.push_back(mk(cyc + 6, 5'b00000, 5'b00001));
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_pending got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_auto_repeat();
    int c0;
    c0 = cyc;
    key_raw[1] = 1'b1;
    exp_q.push_back(mk(c0 + 6, 5'b00010, 5'b00000));
    for (int t = c0 + 16; t < c0 + 47; t += 3) exp_q.push_back(mk(t, 5'b00010, 5'b00000));
    exp_q.push_back(mk(c0 + 47, 5'b00000, 5'b00010));
    repeat (41) @(negedge clk);
    key_raw[1] = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || key_level[1] !== 1'b0) begin
      errors++;
      $display("FAIL repeat_done pending=%0d level=%b required 0 and 0", exp_q.size(),
               key_level[1]);
    end
  endtask

  task automatic test_release_on_repeat();
    int c0;
    c0 = cyc;
    key_raw[1] = 1'b1;
    exp_q.push_back(mk(c0 + 6, 5'b00010, 5'b00000));
    for (int t = c0 + 16; t < c0 + 46; t += 3) exp_q.push_back(mk(t, 5'b00010, 5'b00000));
    // Fall lands on the c0+46 repeat slot: release only.
    exp_q.push_back(mk(c0 + 46, 5'b00000, 5'b00010));
    repeat (40) @(negedge clk);
    key_raw[1] = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL coincide_pending got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    key_raw[3:2] = 2'b11;
    exp_q.push_back(mk(cyc + 6, 5'b01100, 5'b00000));
    repeat (10) @(negedge clk);
    checks++;
    if (key_level !== 5'b01100) begin
      errors++;
      $display("FAIL simul_level got %b required 01100", key_level);
    end
    key_raw[3:2] = 2'b00;
    exp_q.push_back(mk(cyc + 6, 5'b00000, 5'b01100));
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_pending got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_repeat();
    int c0;
    int cr;
    c0 = cyc;
    key_raw[1] = 1'b1;
    exp_q.push_back(mk(c0 + 6, 5'b00010, 5'b00000));
    exp_q.push_back(mk(c0 + 16, 5'b00010, 5'b00000));
    exp_q.push_back(mk(c0 + 19, 5'b00010, 5'b00000));
    repeat (21) @(negedge clk);
    checks++;
    if (key_level[1] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_level got %b required 1", key_level[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (key_level !== '0 || key_press !== '0 || key_release !== '0) begin
      errors++;
      $display("FAIL async_reset level=%b press=%b release=%b required all 0",
               key_level, key_press, key_release);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cr = cyc;
    exp_q.push_back(mk(cr + 6, 5'b00010, 5'b00000));
    for (int t = cr + 16; t < cr + 23; t += 3) exp_q.push_back(mk(t, 5'b00010, 5'b00000));
    exp_q.push_back(mk(cr + 23, 5'b00000, 5'b00010));
    repeat (17) @(negedge clk);
    key_raw[1] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_pending got %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_on_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
